// File: rtl/hist_readout_sched.sv
// hist_readout_sched: steers incoming samples round-robin into four histogram
// channels. On a rising edge of stop4calc it reads every bin back and presents
// the four channel counts summed per bin on a valid/ready output. When all bins
// have been read, it clears the channels.
//
// Ports
//   clk200, rstn            clock, asynchronous active-low reset
//   in_valid, in_data       sample input from the acquisition path
//   stop4calc               level input; its rising edge starts a readout
//   ch_wr, ch_data          one-hot channel write strobe and registered sample
//   rd_en, rd_addr          bin-read pulse and bin index to all channels
//   ch_rd_cnt               four channel counts, valid one cycle after rd_en
//   ch_clr                  clear-all-channels pulse at the end of readout
//   out_valid, out_ready    result handshake
//   out_bin, out_count      bin index and summed count of the current result
//   busy, done              readout in progress / readout complete pulse
//   drop_cnt                (HIST_SCHED_DROP_CNT_EN only) count of samples
//                           ignored during readout, saturating
//
// Optional feature macro: HIST_SCHED_DROP_CNT_EN
module hist_readout_sched #(
    parameter int unsigned DATA_SIZE   = 4,
    parameter int unsigned DATA_NUM    = 16,
    parameter int unsigned LENGTH_SIZE = 6,
    localparam int unsigned CNT_W      = LENGTH_SIZE + 1,
    localparam int unsigned SUM_W      = CNT_W + 2
) (
    input  logic                 clk200,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 stop4calc,
    output logic [3:0]           ch_wr,
    output logic [DATA_SIZE-1:0] ch_data,
    output logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_addr,
    input  logic [4*CNT_W-1:0]   ch_rd_cnt,
    output logic                 ch_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_bin,
    output logic [SUM_W-1:0]     out_count,
    output logic                 busy,
`ifdef HIST_SCHED_DROP_CNT_EN
    output logic                 done,
    output logic [15:0]          drop_cnt
`else
    output logic                 done
`endif
);

    localparam logic [DATA_SIZE-1:0] LAST_BIN = DATA_SIZE'(DATA_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_CAPT,
        S_OUT,
        S_CLEAR
    } state_t;

    state_t               state, state_n;
    logic [1:0]           ptr, ptr_n;
    logic [DATA_SIZE-1:0] bin, bin_n;
    logic                 drain, drain_n;
    logic                 stop_q;
    logic                 start_c;
    logic [SUM_W-1:0]     cnt_sum_c;

    logic [3:0]           ch_wr_n;
    logic [DATA_SIZE-1:0] ch_data_n;
    logic                 rd_en_n;
    logic [DATA_SIZE-1:0] rd_addr_n;
    logic                 clr_n;
    logic                 out_valid_n;
    logic [DATA_SIZE-1:0] out_bin_n;
    logic [SUM_W-1:0]     out_count_n;
    logic                 busy_n;

    assign start_c = stop4calc & ~stop_q;

    // Zero-extended sum of the four channel counts; SUM_W has two bits of headroom.
    always_comb begin
        cnt_sum_c = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_sum_c = cnt_sum_c + SUM_W'(ch_rd_cnt[i*CNT_W +: CNT_W]);
        end
    end

    // State register.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        bin_n       = bin;
        drain_n     = drain;
        ch_wr_n     = 4'b0000;
        ch_data_n   = '0;
        out_bin_n   = out_bin;
        out_count_n = out_count;

        case (state)
            S_IDLE: begin
                // A sample coinciding with the start edge is still written.
                if (in_valid) begin
                    ch_wr_n   = 4'b0001 << ptr;
                    ch_data_n = in_data;
                    ptr_n     = ptr + 2'd1;
                end
                if (start_c) begin
                    state_n = S_DRAIN;
                    drain_n = 1'b0;
                end
            end
            // Two idle cycles let the last channel write land before reading.
            S_DRAIN: begin
                if (drain) begin
                    state_n = S_READ;
                    bin_n   = '0;
                end else begin
                    drain_n = 1'b1;
                end
            end
            S_READ: begin
                state_n = S_CAPT;
            end
            S_CAPT: begin
                out_count_n = cnt_sum_c;
                out_bin_n   = bin;
                state_n     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (bin == LAST_BIN) begin
                        state_n = S_CLEAR;
                    end else begin
                        bin_n   = bin + DATA_SIZE'(1);
                        state_n = S_READ;
                    end
                end
            end
            S_CLEAR: begin
                ptr_n   = '0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line up with it.
        rd_en_n     = (state_n == S_READ);
        rd_addr_n   = rd_en_n ? bin_n : '0;
        out_valid_n = (state_n == S_OUT);
        clr_n       = (state_n == S_CLEAR);
        busy_n      = (state_n != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            bin       <= '0;
            drain     <= 1'b0;
            stop_q    <= 1'b0;
            ch_wr     <= 4'b0000;
            ch_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            ch_clr    <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_count <= '0;
            busy      <= 1'b0;
        end else begin
            ptr       <= ptr_n;
            bin       <= bin_n;
            drain     <= drain_n;
            stop_q    <= stop4calc;
            ch_wr     <= ch_wr_n;
            ch_data   <= ch_data_n;
            rd_en     <= rd_en_n;
            rd_addr   <= rd_addr_n;
            ch_clr    <= clr_n;
            done      <= clr_n;
            out_valid <= out_valid_n;
            out_bin   <= out_bin_n;
            out_count <= out_count_n;
            busy      <= busy_n;
        end
    end

`ifdef HIST_SCHED_DROP_CNT_EN
    // Saturating count of samples ignored while a readout is in progress.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= 16'd0;
        end else if ((state != S_IDLE) && in_valid && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hist_readout_sched.sv
// Self-checking bench for hist_readout_sched: sample steering, full readout,
// back-pressure, start-edge sample, held stop4calc and reset during readout.
module tb_hist_readout_sched;

    localparam int unsigned DS = 4;
    localparam int unsigned DN = 16;
    localparam int unsigned LS = 6;
    localparam int unsigned CW = LS + 1;
    localparam int unsigned SW = CW + 2;
    localparam int unsigned RW = 4 * CW;

    logic          clk200    = 1'b0;
    logic          rstn      = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DS-1:0] in_data   = '0;
    logic          stop4calc = 1'b0;
    logic          out_ready = 1'b1;
    logic [RW-1:0] ch_rd_cnt = '0;
    logic [3:0]    ch_wr;
    logic [DS-1:0] ch_data;
    logic          rd_en;
    logic [DS-1:0] rd_addr;
    logic          ch_clr;
    logic          out_valid;
    logic [DS-1:0] out_bin;
    logic [SW-1:0] out_count;
    logic          busy;
    logic          done;
`ifdef HIST_SCHED_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_ptr = 0;

    typedef struct {
        logic [3:0]    wr;
        logic [DS-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [DS-1:0] bin;
        logic [SW-1:0] cnt;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];

    hist_readout_sched #(
        .DATA_SIZE(DS),
        .DATA_NUM(DN),
        .LENGTH_SIZE(LS)
    ) dut (
        .clk200(clk200),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_data(in_data),
        .stop4calc(stop4calc),
        .ch_wr(ch_wr),
        .ch_data(ch_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .ch_rd_cnt(ch_rd_cnt),
        .ch_clr(ch_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bin(out_bin),
        .out_count(out_count),
        .busy(busy),
`ifdef HIST_SCHED_DROP_CNT_EN
        .done(done),
        .drop_cnt(drop_cnt)
`else
        .done(done)
`endif
    );

    always #5 clk200 = ~clk200;
    always @(posedge clk200) cyc <= cyc + 1;

    // Channel count model; bin 3 carries the fixed counts 5,7,0,64.
    function automatic logic [CW-1:0] model_cnt(input int c, input int b);
        if (b == 3) begin
            case (c)
                0:       return CW'(5);
                1:       return CW'(7);
                2:       return CW'(0);
                default: return CW'(64);
            endcase
        end
        return CW'((c * 29 + b * 11 + 3) % 128);
    endfunction

    function automatic logic [SW-1:0] model_sum(input int b);
        logic [SW-1:0] s = '0;
        for (int c = 0; c < 4; c++) s = s + SW'(model_cnt(c, b));
        return s;
    endfunction

    // Channel read port: counts appear one cycle after rd_en, noise otherwise.
    always @(posedge clk200) begin
        if (rd_en) begin
            for (int c = 0; c < 4; c++) ch_rd_cnt[c*CW +: CW] <= model_cnt(c, int'(rd_addr));
        end else begin
            ch_rd_cnt <= RW'($urandom);
        end
    end

    task automatic push_wr(input logic [DS-1:0] d);
        wr_q.push_back('{wr: 4'(1 << exp_ptr), data: d, cyc: cyc + 1});
        exp_ptr = (exp_ptr + 1) % 4;
    endtask

    // Advance to the next falling edge and check channel writes against the queue.
    task automatic tick();
        wr_t e;
        @(negedge clk200);
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            e = wr_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL ch_wr_missing: got no write at cycle %0d, required ch_wr=%b data=%0d", e.cyc, e.wr, e.data);
        end
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            e = wr_q.pop_front();
            n_tests++;
            if (ch_wr !== e.wr || ch_data !== e.data) begin
                n_fail++;
                $display("FAIL ch_wr: got ch_wr=%b data=%0d, required ch_wr=%b data=%0d", ch_wr, ch_data, e.wr, e.data);
            end
        end else if (ch_wr !== 4'b0000) begin
            n_tests++; n_fail++;
            $display("FAIL ch_wr_unexpected: got ch_wr=%b at cycle %0d, required 0000", ch_wr, cyc);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({ch_wr, ch_data, rd_en, rd_addr, ch_clr, out_valid, out_bin, out_count, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b data=%0d rd=%b addr=%0d clr=%b ov=%b bin=%0d cnt=%0d busy=%b done=%b, required all 0",
                     ch_wr, ch_data, rd_en, rd_addr, ch_clr, out_valid, out_bin, out_count, busy, done);
        end
        rstn = 1'b1;
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b rd_en=%b, required 0 0", busy, rd_en);
        end
    endtask

    task automatic test_samples();
        for (int i = 0; i < 8; i++) begin
            tick();
            in_valid = 1'b1;
            in_data  = DS'(i * 3 + 1);
            push_wr(in_data);
        end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL samples_drained: got %0d pending writes, required 0", wr_q.size());
        end
    endtask

    task automatic run_readout(input int hold_bin, input int abort_bin, input bit sample_at_start,
                               input bit hold_stop, input bit spam);
        res_t          e;
        int            start_cyc;
        int            first_rd   = -1;
        int            rd_cnt     = 0;
        int            done_cnt   = 0;
        int            held       = 0;
        int            spam_edges = 0;
        int            bad        = 0;
        bit            exp_rd     = 1'b0;
        bit            exp_done   = 1'b0;
        bit            finished   = 1'b0;
        bit            aborted    = 1'b0;
        logic [DS-1:0] exp_addr   = '0;
        logic [DS-1:0] hold_b     = '0;
        logic [SW-1:0] hold_c     = '0;
`ifdef HIST_SCHED_DROP_CNT_EN
        logic [15:0]   drop0;
`endif
        for (int b = 0; b < int'(DN); b++) res_q.push_back('{bin: DS'(b), cnt: model_sum(b)});
        tick();
        stop4calc = 1'b1;
        start_cyc = cyc;
        if (sample_at_start) begin
            in_valid = 1'b1;
            in_data  = DS'(10);
            push_wr(in_data);
        end
        tick();
`ifdef HIST_SCHED_DROP_CNT_EN
        drop0 = drop_cnt;
`endif
        in_valid = spam;
        in_data  = DS'($urandom);
        if (spam) spam_edges++;
        if (!hold_stop) stop4calc = 1'b0;
        for (int t = 0; t < 1500 && !finished; t++) begin
            tick();
            if (rd_en === 1'b1) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (done === 1'b1) done_cnt++;
            if (exp_rd) begin
                exp_rd = 1'b0;
                n_tests++;
                if (rd_en !== 1'b1 || rd_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL next_read: got rd_en=%b addr=%0d, required 1 addr=%0d", rd_en, rd_addr, exp_addr);
                end
            end
            if (exp_done) begin
                exp_done = 1'b0;
                n_tests++;
                if (done !== 1'b1 || ch_clr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_clr: got done=%b ch_clr=%b, required 1 1", done, ch_clr);
                end
                in_valid = 1'b0;
                finished = 1'b1;
            end else if (abort_bin >= 0 && out_valid === 1'b1 && int'(out_bin) == abort_bin) begin
                rstn = 1'b0;
                #1;
                n_tests++;
                if ({ch_wr, ch_data, rd_en, rd_addr, ch_clr, out_valid, out_bin, out_count, busy, done} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_outputs: got rd=%b clr=%b ov=%b bin=%0d cnt=%0d busy=%b done=%b, required all 0",
                             rd_en, ch_clr, out_valid, out_bin, out_count, busy, done);
                end
                in_valid = 1'b0;
                tick();
                rstn     = 1'b1;
                res_q.delete();
                exp_ptr  = 0;
                aborted  = 1'b1;
                finished = 1'b1;
            end else begin
                if (spam) spam_edges++;
                if (out_valid === 1'b1 && int'(out_bin) == hold_bin && held < 10) begin
                    if (held == 0) begin
                        hold_b = out_bin;
                        hold_c = out_count;
                    end else begin
                        n_tests++;
                        if (out_bin !== hold_b || out_count !== hold_c) begin
                            n_fail++;
                            $display("FAIL hold_stable: got bin=%0d cnt=%0d, required bin=%0d cnt=%0d", out_bin, out_count, hold_b, hold_c);
                        end
                    end
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    n_tests++;
                    if (res_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL result_extra: got bin=%0d cnt=%0d, required no result", out_bin, out_count);
                    end else begin
                        e = res_q.pop_front();
                        if (out_bin !== e.bin || out_count !== e.cnt) begin
                            n_fail++;
                            $display("FAIL result: got bin=%0d count=%0d, required bin=%0d count=%0d", out_bin, out_count, e.bin, e.cnt);
                        end
                        if (int'(e.bin) == int'(DN) - 1) begin
                            exp_done = 1'b1;
                        end else begin
                            exp_rd   = 1'b1;
                            exp_addr = e.bin + DS'(1);
                        end
                    end
                end
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL readout_timeout: got no completion in 1500 cycles, required done");
        end
        if (aborted) begin
            for (int t = 0; t < 6; t++) begin
                tick();
                if (done !== 1'b0 || ch_clr !== 1'b0 || busy !== 1'b0) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL abort_quiet: got %0d cycles with done/ch_clr/busy, required 0", bad);
            end
        end else begin
            exp_ptr = 0;
            n_tests++;
            if (res_q.size() != 0 || done_cnt != 1 || rd_cnt != int'(DN)) begin
                n_fail++;
                $display("FAIL readout_totals: got pending=%0d done=%0d reads=%0d, required 0 1 %0d", res_q.size(), done_cnt, rd_cnt, DN);
            end
            n_tests++;
            if (first_rd != start_cyc + 3) begin
                n_fail++;
                $display("FAIL drain_len: got first rd_en at cycle %0d, required %0d", first_rd, start_cyc + 3);
            end
            if (hold_bin >= 0) begin
                n_tests++;
                if (held != 10) begin
                    n_fail++;
                    $display("FAIL hold_count: got %0d held cycles, required 10", held);
                end
            end
`ifdef HIST_SCHED_DROP_CNT_EN
            if (spam) begin
                n_tests++;
                if (int'(drop_cnt - drop0) != spam_edges) begin
                    n_fail++;
                    $display("FAIL drop_cnt: got delta %0d, required %0d", drop_cnt - drop0, spam_edges);
                end
            end
`endif
            if (hold_stop) begin
                for (int t = 0; t < 20; t++) begin
                    tick();
                    if (busy !== 1'b0 || rd_en !== 1'b0) bad++;
                end
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL stop_held_retrigger: got %0d busy cycles, required 0", bad);
                end
                stop4calc = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_readout();
        run_readout(-1, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_readout(5, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_sample_and_drop();
        run_readout(-1, -1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_stop_held();
        run_readout(-1, -1, 1'b0, 1'b1, 1'b0);
        run_readout(-1, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_out();
        tick();
        in_valid = 1'b1;
        in_data  = DS'(6);
        push_wr(in_data);
        tick();
        in_valid = 1'b0;
        tick();
        run_readout(-1, 9, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = DS'(9);
        push_wr(in_data);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL ptr_after_reset: got %0d pending writes, required 0", wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_samples();
        test_readout();
        test_backpressure();
        test_start_sample_and_drop();
        test_stop_held();
        test_reset_in_out();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hist_readout_sched.md
HIST_READOUT_SCHED -- requirements
Module: hist_readout_sched

Interface
- REQ-001 Parameter DATA_SIZE, default 4: sample width in bits and bin-index width.
- REQ-002 Parameter DATA_NUM, default 16: number of histogram bins per channel.
- REQ-003 Parameter LENGTH_SIZE, default 6: per-channel count width is CNT_W = LENGTH_SIZE+1 and output sum width is SUM_W = CNT_W+2.
- REQ-004 clk200, input, 1: sole clock; all logic on its rising edge.
- REQ-005 rstn, input, 1: reset, asynchronous, active-low.
- REQ-006 in_valid, input, 1: sample strobe from the acquisition path.
- REQ-007 in_data, input, DATA_SIZE: sample value.
- REQ-008 stop4calc, input, 1: request to stop acquisition and read out.
- REQ-009 ch_wr, output, 4: one-hot write strobe to histogram channels 0..3.
- REQ-010 ch_data, output, DATA_SIZE: registered sample, shared by all channels.
- REQ-011 rd_en, output, 1: bin-read pulse to all channels.
- REQ-012 rd_addr, output, DATA_SIZE: bin index being read.
- REQ-013 ch_rd_cnt, input, 4*CNT_W: channel counts, channel i in bits [i*CNT_W +: CNT_W], valid exactly 1 cycle after rd_en.
- REQ-014 ch_clr, output, 1: clear-all-channels pulse.
- REQ-015 out_valid / out_ready, output / input, 1 each: result handshake.
- REQ-016 out_bin, output, DATA_SIZE: bin index of the current result.
- REQ-017 out_count, output, SUM_W: sum of the four channel counts for out_bin.
- REQ-018 busy, output, 1: high in every state except IDLE.
- REQ-019 done, output, 1: 1-cycle pulse when readout completes.

Function
- REQ-020 FSM states: IDLE, DRAIN, READ, CAPT, OUT, CLEAR.
- REQ-021 IDLE, in_valid=1: ch_wr[ptr] and ch_data=in_data are registered for exactly one cycle (1-cycle latency); the 2-bit ptr increments, wrapping 3->0.
- REQ-022 Start condition is the rising edge of stop4calc (stop4calc=1 while its previous-cycle registered value is 0); a start seen in IDLE moves the FSM to DRAIN; stop4calc held high does not retrigger.
- REQ-023 A sample with in_valid=1 in the same cycle as the start edge is still accepted and written.
- REQ-024 In any state other than IDLE, in_valid is ignored: no ch_wr and no ptr change.
- REQ-025 DRAIN lasts exactly 2 cycles, so in-flight channel writes can complete; bin is set to 0, then the FSM moves to READ.
- REQ-026 READ: rd_en=1 and rd_addr=bin for exactly 1 cycle, then CAPT.
- REQ-027 CAPT: out_count is registered as the zero-extended sum of the four ch_rd_cnt fields (no overflow possible), out_bin=bin, then OUT.
- REQ-028 OUT: out_valid=1, and out_bin/out_count are held stable until out_ready=1; a transfer occurs on the cycle where out_valid and out_ready are both 1.
- REQ-029 On transfer: if bin=DATA_NUM-1, go to CLEAR; otherwise bin increments and the FSM returns to READ; minimum 3 cycles per bin.
- REQ-030 CLEAR: ch_clr=1 and done=1 for 1 cycle; ptr is reset to 0; next state IDLE.
- REQ-031 A stop4calc edge during a readout (any non-IDLE state) is ignored.
- REQ-032 When not stated otherwise, all outputs are 0, except that out_bin and out_count hold their last values.

Reset
- REQ-033 On rstn=0, the FSM returns to IDLE immediately, with ptr=0, bin=0, and stop4calc edge register=0.
- REQ-034 On rstn=0, ch_wr, ch_data, rd_en, rd_addr, ch_clr, out_valid, out_bin, out_count, busy and done are all 0.
- REQ-035 A reset during readout abandons it: no done and no ch_clr pulse, and channel contents are left untouched.

Configuration
- REQ-036 Macro HIST_SCHED_DROP_CNT_EN, when defined, adds output drop_cnt (16 bits).
- REQ-037 drop_cnt counts in_valid cycles ignored under REQ-024, saturates at 0xFFFF, and resets to 0 only on rstn.
- REQ-038 Without HIST_SCHED_DROP_CNT_EN, the drop_cnt port and counter do not exist, and all other behaviour is identical.

Verification
- REQ-039 Send 8 samples on consecutive cycles -> ch_wr sequence is 0001,0010,0100,1000,0001,…, each 1 cycle after in_valid, with ch_data matching.
- REQ-040 Pulse stop4calc with model counts ch0..3 = 5,7,0,64 for bin 3 and out_ready always 1 -> out_bin=3 gives out_count=76; 16 results for bins 0..15 are produced, then one ch_clr+done pulse.
- REQ-041 Hold out_ready=0 for 10 cycles at bin 5 -> out_valid stays 1 with stable data; the next rd_en comes 1 cycle after the transfer.
- REQ-042 Assert in_valid together with the stop4calc edge -> that sample is written; in_valid during readout -> no ch_wr (and drop_cnt increments if enabled).
- REQ-043 Hold stop4calc high through the whole readout -> after done, FSM stays in IDLE, with no second readout until stop4calc goes low then high.
- REQ-044 Pull rstn low in OUT at bin 9 -> all outputs are 0 immediately, and no done/ch_clr is seen; after release, the sample ptr restarts at channel 0.
